// File: rtl/alarm_pkg.sv
// Shared types and bit-vector helpers for the alarm latch bank.
// Helpers operate on a fixed MAX_CH-wide vector; callers zero-extend narrower banks.
package alarm_pkg;

  localparam int MAX_CH = 32;
  localparam int LSB_W  = $clog2(MAX_CH);
  localparam int PCNT_W = $clog2(MAX_CH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_LATCHED
  } ch_state_e;

  // Returns 0 for an all-zero vector; callers gate on a non-zero input.
  function automatic logic [LSB_W-1:0] lowest_set(input logic [MAX_CH-1:0] v);
    logic [LSB_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = LSB_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [PCNT_W-1:0] popcount(input logic [MAX_CH-1:0] v);
    logic [PCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      n = n + PCNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One sticky alarm latch; debounce FSM built only with ALARM_LATCH_DEBOUNCE_EN.
// trip is asserted in the cycle whose closing edge moves the channel into its latched state.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  input  logic clr,
  output logic q,
  output logic qb,
  output logic trip
);

  logic q_d, q_q;
  logic qb_d, qb_q;

`ifdef ALARM_LATCH_DEBOUNCE_EN
  localparam int CNT_BITS = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_BITS-1:0] CNT_DONE = CNT_BITS'(DEBOUNCE);

  ch_state_e           state_d, state_q;
  logic [CNT_BITS-1:0] cnt_d, cnt_q;
  logic [CNT_BITS-1:0] cnt_inc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_BITS'(1);
    case (state_q)
      ST_IDLE: begin
        if (d) begin
          cnt_d   = CNT_BITS'(1);
          state_d = (CNT_DONE == CNT_BITS'(1)) ? ST_LATCHED : ST_ARM;
        end
      end
      ST_ARM: begin
        if (!d) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_DONE) state_d = ST_LATCHED;
        end
      end
      ST_LATCHED: begin
        state_d = ST_LATCHED;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // A clearing edge always wins over qualification.
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
    q_d  = (state_d == ST_LATCHED);
    qb_d = ~q_d;
    trip = (state_q != ST_LATCHED) && (state_d == ST_LATCHED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE > 0);

  always_comb begin
    q_d  = clr ? 1'b0 : (q_q | d);
    qb_d = ~q_d;
    trip = d & ~q_q & ~clr;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q  <= 1'b0;
      qb_q <= 1'b1;
    end else begin
      q_q  <= q_d;
      qb_q <= qb_d;
    end
  end

  assign q  = q_q;
  assign qb = qb_q;

endmodule

// File: rtl/alarm_latch_bank.sv
// Bank of WIDTH sticky alarm latches with maskable irq, first-trip capture and saturating trip count.
// Debounce qualification is enabled by defining ALARM_LATCH_DEBOUNCE_EN; WIDTH is limited to MAX_CH.
module alarm_latch_bank
  import alarm_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int DEBOUNCE = 3,
  parameter  int CNT_W    = 8,
  localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] clr,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             irq,
  output logic             first_valid,
  output logic [IDX_W-1:0] first_idx,
  output logic [CNT_W-1:0] trip_cnt
);

  localparam int SUM_W = CNT_W + PCNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  q_vec;
  logic [WIDTH-1:0]  qb_vec;
  logic [WIDTH-1:0]  trip;
  logic [WIDTH-1:0]  q_nxt;
  logic [MAX_CH-1:0] trip_ext;
  logic [SUM_W-1:0]  cnt_sum;

  logic             first_valid_d, first_valid_q;
  logic [IDX_W-1:0] first_idx_d, first_idx_q;
  logic [CNT_W-1:0] trip_cnt_d, trip_cnt_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    alarm_channel #(
      .DEBOUNCE(DEBOUNCE)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .d    (d[i]),
      .clr  (clr[i]),
      .q    (q_vec[i]),
      .qb   (qb_vec[i]),
      .trip (trip[i])
    );
  end

  always_comb begin
    trip_ext = MAX_CH'(trip);
    // Latched channels only leave via clr, and a clearing edge never trips.
    q_nxt    = (q_vec & ~clr) | trip;

    cnt_sum    = SUM_W'(trip_cnt_q) + SUM_W'(popcount(trip_ext));
    trip_cnt_d = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];

    first_valid_d = first_valid_q;
    first_idx_d   = first_idx_q;
    if (q_nxt == '0) begin
      first_valid_d = 1'b0;
    end else if (!first_valid_q && (trip != '0)) begin
      first_valid_d = 1'b1;
      first_idx_d   = IDX_W'(lowest_set(trip_ext));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
      trip_cnt_q    <= '0;
    end else begin
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
      trip_cnt_q    <= trip_cnt_d;
    end
  end

  assign q           = q_vec;
  assign qb          = qb_vec;
  assign irq         = |(q_vec & ~mask);
  assign first_valid = first_valid_q;
  assign first_idx   = first_idx_q;
  assign trip_cnt    = trip_cnt_q;

endmodule

// File: tb/tb_alarm_latch_bank.sv
// Directed bench for alarm_latch_bank; QUAL tracks ALARM_LATCH_DEBOUNCE_EN (3 edges with it, 1 without).
module tb_alarm_latch_bank;

`ifdef ALARM_LATCH_DEBOUNCE_EN
  localparam int QUAL = 3;
`else
  localparam int QUAL = 1;
`endif

  logic       clock;
  logic       reset;
  logic [3:0] d, clr, mask;
  logic [3:0] q, qb;
  logic       irq, first_valid;
  logic [1:0] first_idx;
  logic [7:0] trip_cnt;

  logic [3:0] d_s, clr_s, mask_s;
  logic [3:0] q_s, qb_s;
  logic       irq_s, fv_s;
  logic [1:0] fi_s;
  logic [1:0] tc_s;

  int n_vec = 0;
  int n_bad = 0;

  alarm_latch_bank #(.WIDTH(4), .DEBOUNCE(3), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .d(d), .clr(clr), .mask(mask),
    .q(q), .qb(qb), .irq(irq), .first_valid(first_valid),
    .first_idx(first_idx), .trip_cnt(trip_cnt)
  );

  alarm_latch_bank #(.WIDTH(4), .DEBOUNCE(3), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .d(d_s), .clr(clr_s), .mask(mask_s),
    .q(q_s), .qb(qb_s), .irq(irq_s), .first_valid(fv_s),
    .first_idx(fi_s), .trip_cnt(tc_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; d = '0; clr = '0; mask = '0;
    d_s = '0; clr_s = '0; mask_s = '0;
    #12;
    chk("rst_q", q, 4'h0);
    chk("rst_qb", qb, 4'hF);
    chk("rst_irq", irq, 1'b0);
    chk("rst_cnt", trip_cnt, 8'd0);
    chk("rst_fv", first_valid, 1'b0);
    chk("rst_fi", first_idx, 2'd0);
    chk("rst_sat_cnt", tc_s, 2'd0);
    reset = 1'b1;

    repeat (10) tick();
    chk("idle_q", q, 4'h0);
    chk("idle_qb", qb, 4'hF);
    chk("idle_cnt", trip_cnt, 8'd0);
    chk("idle_fv", first_valid, 1'b0);

`ifdef ALARM_LATCH_DEBOUNCE_EN
    d = 4'b0100;
    tick(); tick();
    d = 4'b0000;
    tick();
    chk("short_pulse_q", q, 4'h0);
    chk("short_pulse_cnt", trip_cnt, 8'd0);
`endif

    // Channel 2 qualifies; q rises on the QUAL-th edge.
    d = 4'b0100;
    repeat (QUAL - 1) tick();
    chk("pre_qual_q", q, 4'h0);
    tick();
    chk("qual_q", q, 4'b0100);
    chk("qual_qb", qb, 4'b1011);
    chk("qual_cnt", trip_cnt, 8'd1);
    chk("qual_fi", first_idx, 2'd2);
    chk("qual_fv", first_valid, 1'b1);
    chk("qual_irq", irq, 1'b1);
    d = 4'b0000;

    clr = 4'b0100;
    tick();
    clr = 4'b0000;
    chk("clr2_q", q, 4'h0);
    chk("clr2_fv", first_valid, 1'b0);
    chk("clr2_fi_stale", first_idx, 2'd2);
    chk("clr2_cnt", trip_cnt, 8'd1);

    // Simultaneous trips on 1 and 3 with channel 1 masked.
    mask = 4'b0010;
    d = 4'b1010;
    repeat (QUAL) tick();
    chk("dual_q", q, 4'b1010);
    chk("dual_fi", first_idx, 2'd1);
    chk("dual_fv", first_valid, 1'b1);
    chk("dual_cnt", trip_cnt, 8'd3);
    chk("dual_irq", irq, 1'b1);
    mask = 4'b1010;
    #1;
    chk("mask_irq", irq, 1'b0);
    chk("mask_q", q, 4'b1010);

    // clr on the qualifying edge wins; channel re-arms from zero.
    d = 4'b0001;
    repeat (QUAL - 1) tick();
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    chk("clrwin_q", q, 4'b1010);
    chk("clrwin_cnt", trip_cnt, 8'd3);
    repeat (QUAL - 1) tick();
    chk("rearm_pre_q", q, 4'b1010);
    tick();
    chk("rearm_q", q, 4'b1011);
    chk("rearm_cnt", trip_cnt, 8'd4);
    chk("rearm_fi", first_idx, 2'd1);

    d = 4'b0000;
    clr = 4'b1011;
    tick();
    clr = 4'b0000;
    chk("clrall_q", q, 4'h0);
    chk("clrall_fv", first_valid, 1'b0);
    chk("clrall_fi", first_idx, 2'd1);
    chk("clrall_cnt", trip_cnt, 8'd4);

    // Clear of ch3 and trip of ch0 on one edge: first_valid holds, first_idx unchanged.
    d = 4'b1000;
    repeat (QUAL) tick();
    chk("ch3_fi", first_idx, 2'd3);
    chk("ch3_cnt", trip_cnt, 8'd5);
    d = 4'b0001;
    repeat (QUAL - 1) tick();
    clr = 4'b1000;
    tick();
    clr = 4'b0000;
    chk("swap_q", q, 4'b0001);
    chk("swap_fv", first_valid, 1'b1);
    chk("swap_fi", first_idx, 2'd3);
    chk("swap_cnt", trip_cnt, 8'd6);
    d = 4'b0000;
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    chk("swap_clr_fv", first_valid, 1'b0);

    // Saturating 2-bit counter on the second instance.
    for (int k = 1; k <= 5; k++) begin
      d_s = 4'b0001;
      repeat (QUAL) tick();
      chk($sformatf("sat_cnt_%0d", k), tc_s, (k > 3) ? 32'd3 : 32'(k));
      d_s = 4'b0000;
      clr_s = 4'b0001;
      tick();
      clr_s = 4'b0000;
    end
    chk("sat_q_clear", q_s, 4'h0);

    // Asynchronous reset with a latched channel and others mid-qualification.
    mask = 4'b0000;
    d = 4'b0010;
    repeat (QUAL) tick();
    chk("pre_rst_q", q, 4'b0010);
    chk("pre_rst_cnt", trip_cnt, 8'd7);
    d = 4'b0101;
    repeat (QUAL - 1) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_q", q, 4'h0);
    chk("arst_qb", qb, 4'hF);
    chk("arst_irq", irq, 1'b0);
    chk("arst_cnt", trip_cnt, 8'd0);
    chk("arst_fv", first_valid, 1'b0);
    chk("arst_fi", first_idx, 2'd0);
    #1;
    reset = 1'b1;
    repeat (QUAL - 1) tick();
    chk("requal_pre_q", q, 4'h0);
    tick();
    chk("requal_q", q, 4'b0101);
    chk("requal_cnt", trip_cnt, 8'd2);
    chk("requal_fi", first_idx, 2'd0);
    chk("requal_fv", first_valid, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
